// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side, register-file, forwarding and execute-side signals of the operand stage.
interface operand_fetch_if #(parameter int XLEN = 64);
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic            in_use_rs1, in_use_rs2;
    logic [4:0]      rf_read_addr1, rf_read_addr2;
    logic [XLEN-1:0] rf_read_data1, rf_read_data2;
    logic            ex_fwd_valid, ex_is_load;
    logic [4:0]      ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            mem_fwd_valid;
    logic [4:0]      mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_data;
    logic            flush;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_pc, out_rs1_val, out_rs2_val;
    logic [4:0]      out_rd;
    logic [31:0]     stall_count;

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2,
               rf_read_data1, rf_read_data2, ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_is_load,
               mem_fwd_valid, mem_fwd_rd, mem_fwd_data, flush, out_ready,
        output in_ready, rf_read_addr1, rf_read_addr2, out_valid, out_pc, out_rd,
               out_rs1_val, out_rs2_val, stall_count
    );

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2,
               rf_read_data1, rf_read_data2, ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_is_load,
               mem_fwd_valid, mem_fwd_rd, mem_fwd_data, flush, out_ready,
        input  in_ready, rf_read_addr1, rf_read_addr2, out_valid, out_pc, out_rd,
               out_rs1_val, out_rs2_val, stall_count
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: RV64 operand stage with EX/MEM forwarding, load-use stall and a valid/ready output register.
module operand_fetch #(parameter int XLEN = 64) (
    input logic           clk,
    input logic           rst,
    operand_fetch_if.slave bus
);
    logic            ex1, ex2, mem1, mem2, hazard, capture;
    logic [XLEN-1:0] op1, op2;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    assign bus.rf_read_addr1 = bus.in_rs1;
    assign bus.rf_read_addr2 = bus.in_rs2;
    assign bus.in_ready      = !hazard && !bus.flush && (!valid_q || bus.out_ready);
    assign bus.out_valid     = valid_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_rs1_val   = rs1_q;
    assign bus.out_rs2_val   = rs2_q;
    assign bus.stall_count   = stall_cnt_q;

    always_comb begin
        ex1  = bus.ex_fwd_valid && bus.ex_fwd_rd == bus.in_rs1 && bus.in_rs1 != 5'd0 && bus.in_use_rs1;
        ex2  = bus.ex_fwd_valid && bus.ex_fwd_rd == bus.in_rs2 && bus.in_rs2 != 5'd0 && bus.in_use_rs2;
        mem1 = bus.mem_fwd_valid && bus.mem_fwd_rd == bus.in_rs1 && bus.in_rs1 != 5'd0 && bus.in_use_rs1;
        mem2 = bus.mem_fwd_valid && bus.mem_fwd_rd == bus.in_rs2 && bus.in_rs2 != 5'd0 && bus.in_use_rs2;
        // a load in EX has no data yet, so its match falls through to MEM/regfile and stalls instead
        op1  = bus.in_rs1 == 5'd0 ? '0 : (ex1 && !bus.ex_is_load) ? bus.ex_fwd_data :
               mem1 ? bus.mem_fwd_data : bus.rf_read_data1;
        op2  = bus.in_rs2 == 5'd0 ? '0 : (ex2 && !bus.ex_is_load) ? bus.ex_fwd_data :
               mem2 ? bus.mem_fwd_data : bus.rf_read_data2;
        hazard  = bus.in_valid && bus.ex_is_load && (ex1 || ex2);
        capture = bus.in_valid && !hazard && !bus.flush && (!valid_q || bus.out_ready);
        valid_d = bus.flush ? 1'b0 : capture ? 1'b1 : (valid_q && bus.out_ready) ? 1'b0 : valid_q;
        pc_d    = capture ? bus.in_pc : pc_q;
        rd_d    = capture ? bus.in_rd : rd_q;
        rs1_d   = capture ? op1 : rs1_q;
        rs2_d   = capture ? op2 : rs2_q;
        stall_cnt_d = (hazard && !bus.flush && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch with a rule-level reference model and random stimulus.
module tb_operand_fetch;
    localparam int XLEN = 64;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] v1;
        logic [63:0] v2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rf [32];
    exp_t        q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        m_ov = 1'b0;
    logic [31:0] m_sc = '0;
    logic        p_cap = 1'b0, p_flush = 1'b0, p_hz = 1'b0, p_ordy = 1'b0;
    logic [31:0] sc0;
    logic [63:0] h1, h2;

    always #5 clk = ~clk;

    operand_fetch_if #(.XLEN(XLEN)) bus();
    operand_fetch #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.rf_read_data1 = rf[bus.rf_read_addr1];
    assign bus.rf_read_data2 = rf[bus.rf_read_addr2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // operand value straight from the selection rules
    function automatic logic [63:0] ref_op(input logic [4:0] rs, input logic u);
        if (rs == 5'd0) return 64'd0;
        if (u && bus.ex_fwd_valid && bus.ex_fwd_rd == rs && !bus.ex_is_load) return bus.ex_fwd_data;
        if (u && bus.mem_fwd_valid && bus.mem_fwd_rd == rs) return bus.mem_fwd_data;
        return rf[rs];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (p_flush) begin
            m_ov = 1'b0;
            q.delete();
        end else if (p_cap) m_ov = 1'b1;
        else if (m_ov && p_ordy) m_ov = 1'b0;
        if (p_hz && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
        bus.in_use_rs1 = 0; bus.in_use_rs2 = 0;
        bus.ex_fwd_valid = 0; bus.ex_fwd_rd = '0; bus.ex_fwd_data = '0; bus.ex_is_load = 0;
        bus.mem_fwd_valid = 0; bus.mem_fwd_rd = '0; bus.mem_fwd_data = '0;
        bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic op(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic u1, input logic u2);
        bus.in_valid = 1; bus.in_pc = pc; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
        bus.in_use_rs1 = u1; bus.in_use_rs2 = u2;
    endtask

    task automatic fwd(input logic exv, input logic [4:0] exrd, input logic [63:0] exd, input logic exl,
                       input logic memv, input logic [4:0] memrd, input logic [63:0] memd);
        bus.ex_fwd_valid = exv; bus.ex_fwd_rd = exrd; bus.ex_fwd_data = exd; bus.ex_is_load = exl;
        bus.mem_fwd_valid = memv; bus.mem_fwd_rd = memrd; bus.mem_fwd_data = memd;
    endtask

    task automatic settle();
        logic hz, er;
        exp_t e;
        hz = bus.in_valid && bus.ex_fwd_valid && bus.ex_is_load && bus.ex_fwd_rd != 5'd0 &&
             ((bus.in_use_rs1 && bus.in_rs1 == bus.ex_fwd_rd) || (bus.in_use_rs2 && bus.in_rs2 == bus.ex_fwd_rd));
        er = !hz && !bus.flush && (!m_ov || bus.out_ready);
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(er));
        chk("rf_addr", 64'({bus.rf_read_addr1, bus.rf_read_addr2}), 64'({bus.in_rs1, bus.in_rs2}));
        if (bus.in_valid && er) begin
            e.pc = bus.in_pc;
            e.rd = bus.in_rd;
            e.v1 = ref_op(bus.in_rs1, bus.in_use_rs1);
            e.v2 = ref_op(bus.in_rs2, bus.in_use_rs2);
            q.push_back(e);
        end
        p_cap = bus.in_valid && er;
        p_flush = bus.flush;
        p_hz = hz && !bus.flush;
        p_ordy = bus.out_ready;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
            chk("stall_count", 64'(bus.stall_count), 64'(m_sc));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got pc %h, expected no output", bus.out_pc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
                    chk("out_rs1_val", bus.out_rs1_val, e.v1);
                    chk("out_rs2_val", bus.out_rs2_val, e.v2);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        idle();
        #2;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_pc", bus.out_pc, 64'd0);
        chk("rst_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_rs1", bus.out_rs1_val, 64'd0);
        chk("rst_rs2", bus.out_rs2_val, 64'd0);
        chk("rst_sc", 64'(bus.stall_count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #2 rst = 0;

        // basic accept
        rf[5] = 64'h11; rf[6] = 64'h22;
        next_cycle(); idle(); op(64'h1000, 5, 6, 3, 1, 1); settle();
        next_cycle(); idle(); settle();
        chk("basic_valid", 64'(bus.out_valid), 64'd1);
        chk("basic_rs1", bus.out_rs1_val, 64'h11);
        chk("basic_rs2", bus.out_rs2_val, 64'h22);
        chk("basic_pc", bus.out_pc, 64'h1000);

        // forwarding priority
        next_cycle(); idle(); op(64'h2000, 5, 6, 4, 1, 1); fwd(1, 5, 64'hAA, 0, 1, 5, 64'hBB); settle();
        next_cycle(); idle(); settle();
        chk("fwd_ex", bus.out_rs1_val, 64'hAA);
        next_cycle(); idle(); op(64'h2004, 5, 6, 4, 1, 1); fwd(0, 5, 64'hAA, 0, 1, 5, 64'hBB); settle();
        next_cycle(); idle(); settle();
        chk("fwd_mem", bus.out_rs1_val, 64'hBB);
        next_cycle(); idle(); op(64'h2008, 0, 6, 0, 1, 1); fwd(1, 0, 64'hAA, 0, 1, 0, 64'hBB); settle();
        next_cycle(); idle(); settle();
        chk("fwd_x0", bus.out_rs1_val, 64'd0);
        chk("fwd_x0_rs2", bus.out_rs2_val, 64'h22);

        // load-use stall then MEM forward
        sc0 = m_sc;
        next_cycle(); idle(); op(64'h3000, 1, 7, 8, 1, 1); fwd(1, 7, 64'h99, 1, 0, 0, 0); settle();
        chk("lu_stall", 64'(bus.in_ready), 64'd0);
        next_cycle(); idle(); op(64'h3000, 1, 7, 8, 1, 1); fwd(0, 0, 0, 0, 1, 7, 64'h77); settle();
        chk("lu_ready", 64'(bus.in_ready), 64'd1);
        chk("lu_count", 64'(bus.stall_count), 64'(sc0 + 32'd1));
        next_cycle(); idle(); settle();
        chk("lu_fwd", bus.out_rs2_val, 64'h77);
        next_cycle(); idle(); op(64'h3008, 1, 7, 8, 1, 0); fwd(1, 7, 64'h99, 1, 0, 0, 0); settle();
        chk("lu_unused", 64'(bus.in_ready), 64'd1);

        // backpressure
        next_cycle(); idle(); op(64'h4000, 2, 3, 9, 1, 1); settle();
        h1 = 64'd0; h2 = 64'd0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); idle(); bus.out_ready = 0; op(64'h4008, 4, 5, 10, 1, 1); settle();
            if (i == 0) begin h1 = bus.out_rs1_val; h2 = bus.out_rs2_val; end
            chk("bp_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_pc", bus.out_pc, 64'h4000);
            chk("bp_rs1", bus.out_rs1_val, h1);
            chk("bp_rs2", bus.out_rs2_val, h2);
        end
        next_cycle(); idle(); op(64'h4008, 4, 5, 10, 1, 1); settle();
        chk("bp_cap", 64'(bus.in_ready), 64'd1);
        next_cycle(); idle(); bus.out_ready = 0; settle();
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_newpc", bus.out_pc, 64'h4008);

        // flush with held instruction and a new one offered
        next_cycle(); idle(); bus.out_ready = 0; op(64'h5000, 1, 2, 3, 1, 1); bus.flush = 1; settle();
        chk("flush_ready", 64'(bus.in_ready), 64'd0);
        next_cycle(); idle(); settle();
        chk("flush_valid", 64'(bus.out_valid), 64'd0);

        // async reset while holding and stalling
        next_cycle(); idle(); bus.out_ready = 0; op(64'h6000, 1, 2, 3, 1, 1); settle();
        next_cycle(); idle(); bus.out_ready = 0; op(64'h6008, 1, 7, 3, 1, 1); fwd(1, 7, 0, 1, 0, 0, 0); settle();
        next_cycle(); idle(); bus.out_ready = 0; settle();
        #1 rst = 1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_sc", 64'(bus.stall_count), 64'd0);
        m_ov = 0; m_sc = '0; q.delete();
        p_cap = 0; p_flush = 0; p_hz = 0; p_ordy = 0;
        rst = 0;

        // saturation of stall_count
        next_cycle(); idle(); settle();
        #1 force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt_q;
        m_sc = 32'hFFFF_FFFD;
        for (int i = 0; i < 5; i++) begin
            next_cycle(); idle(); op(64'h7000, 7, 0, 1, 1, 0); fwd(1, 7, 0, 1, 0, 0, 0); settle();
        end
        next_cycle(); idle(); settle();
        chk("sat", 64'(bus.stall_count), 64'hFFFF_FFFF);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = {$urandom, $urandom};
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.in_pc = {$urandom, $urandom};
            bus.in_rs1 = 5'($urandom_range(0, 3));
            bus.in_rs2 = 5'($urandom_range(0, 3));
            bus.in_rd = 5'($urandom_range(0, 31));
            bus.in_use_rs1 = 1'($urandom_range(0, 1));
            bus.in_use_rs2 = 1'($urandom_range(0, 1));
            bus.ex_fwd_valid = 1'($urandom_range(0, 1));
            bus.ex_fwd_rd = 5'($urandom_range(0, 3));
            bus.ex_fwd_data = {$urandom, $urandom};
            bus.ex_is_load = $urandom_range(0, 2) == 0;
            bus.mem_fwd_valid = 1'($urandom_range(0, 1));
            bus.mem_fwd_rd = 5'($urandom_range(0, 3));
            bus.mem_fwd_data = {$urandom, $urandom};
            bus.flush = $urandom_range(0, 19) == 0;
            bus.out_ready = $urandom_range(0, 9) < 7;
            settle();
        end

        for (int i = 0; i < 3; i++) begin
            next_cycle(); idle(); settle();
        end
        chk("q_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute operand stage of the RV64 pipeline. It drives both integer register file read ports and resolves RAW hazards by forwarding from EX and MEM. It detects load-use hazards and stalls for them. It holds the resolved operands in a valid/ready output register that feeds the execute stage.

## Interface
- XLEN, 64, operand/PC width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_use_rs1, in_use_rs2  in  1  instruction reads rs1/rs2
- rf_read_addr1, rf_read_addr2  out  5  register file read addresses (combinational = in_rs1/in_rs2)
- rf_read_data1, rf_read_data2  in  XLEN  register file read data (combinational)
- ex_fwd_valid  in  1  EX holds an instruction writing ex_fwd_rd
- ex_fwd_rd  in  5  EX destination
- ex_fwd_data  in  XLEN  EX result
- ex_is_load  in  1  EX instruction is a load (result not yet available)
- mem_fwd_valid, mem_fwd_rd, mem_fwd_data  in  1/5/XLEN  same for MEM (data always final)
- flush  in  1  kill the held instruction and any capture this cycle
- out_valid  out  1  operands valid toward EX
- out_ready  in  1  EX accepts
- out_pc  out  XLEN; out_rd  out  5; out_rs1_val, out_rs2_val  out  XLEN  registered operands
- stall_count  out  32  saturating count of load-use stall cycles

## Operation
- Source match for rsN: a stage matches when its fwd_valid=1, its fwd_rd=rsN, rsN≠0, and in_use_rsN=1.
- Operand select per source, in priority order:
  - rsN=0: value is 0.
  - EX matches and ex_is_load=0: ex_fwd_data.
  - MEM matches: mem_fwd_data.
  - Otherwise: rf_read_data.
- No writeback forwarding. The register file writes on the falling edge, so a same-cycle writeback is visible in rf_read_data before the rising edge.
- Load-use hazard: in_valid=1 and EX matches either used source with ex_is_load=1.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Capture (in_valid && in_ready): the output register loads pc, rd and both resolved operands; out_valid is set to 1.
- Drain: out_valid && out_ready with no capture sets out_valid to 0.
- Capture and drain in the same cycle: the output register updates to the new instruction and out_valid stays 1.
- Held contents are stable while out_valid && !out_ready.
- flush: out_valid is set to 0 and nothing is captured, regardless of the other inputs. Data fields may keep stale values.
- stall_count increments on each cycle with hazard=1 and flush=0. It saturates at 0xFFFFFFFF.
- Unused sources (in_use_rsN=0) never cause a stall. Their operand value is whatever the select logic produces.

## Timing
- Reset (asynchronous, immediate): out_valid=0, out_pc=0, out_rd=0, out_rs1_val=0, out_rs2_val=0, stall_count=0.
- in_ready is combinational during reset; out_valid=0, so in_ready follows only hazard and flush.
- Latency: operands are presented on out_* one cycle after acceptance.
- Throughput is 1 per cycle when EX is always ready and there are no hazards.
- Load-use stall is exactly one cycle. The next cycle the load has moved to MEM and mem_fwd supplies the data.
- in_ready and rf_read_addr* are purely combinational from inputs and the current out_valid. No combinational path exists from out_ready to out_*.
- Reset asserted mid-stall or mid-handshake discards the held instruction. No output is produced until a new capture.

## Test plan
- Reset then accept in_pc=0x1000, rs1=5, rs2=6, regfile x5=0x11, x6=0x22, no forwarding:
  - Required: next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22, out_pc=0x1000.
- Forward priority: EX rd=5 data=0xAA, MEM rd=5 data=0xBB, regfile x5=0x11:
  - Required: out_rs1_val=0xAA.
  - Repeat with EX invalid: required 0xBB.
  - Repeat with rs1=0 and all rd=0: required 0.
- Load-use: EX load rd=7, in rs2=7, use_rs2=1:
  - Required: in_ready=0 for one cycle and stall_count=1.
  - Next cycle MEM rd=7 data=0x77: required capture with out_rs2_val=0x77.
  - Same case with use_rs2=0: required no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1:
  - Required: out_* held constant and in_ready=0.
  - Then out_ready=1: required drain and new capture in the same cycle, out_valid stays 1.
- flush while out_valid=1 and in_valid=1:
  - Required: next cycle out_valid=0 and no capture.
  - Async rst pulse mid-cycle: required out_valid=0 immediately and stall_count=0.
- stall_count preset near 0xFFFFFFFF by forcing repeated hazards:
  - Required: saturates at 0xFFFFFFFF and never wraps to 0.
